// File: rtl/uncache_axi_bridge_pkg.sv
// Shared encodings for the uncached-request to AXI4 single-beat bridge.
package uncache_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_AR   = 6'b000010,
    ST_R    = 6'b000100,
    ST_AW_W = 6'b001000,
    ST_B    = 6'b010000,
    ST_DONE = 6'b100000
  } state_e;

endpackage

// File: rtl/uncache_axi_bridge.sv
// Turns one held uncached word request into a single-beat AXI4 read or write,
// pulsing reload when the response arrives. One transaction in flight.
module uncache_axi_bridge
  import uncache_axi_bridge_pkg::*;
#(
  parameter int unsigned     ID_W  = 4,
  parameter logic [ID_W-1:0] RD_ID = ID_W'(1),
  parameter logic [ID_W-1:0] WR_ID = ID_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic [STRB_W-1:0] req_wsel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              reload,
  output logic [DATA_W-1:0] rdata,
  output logic              resp_err,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata_axi,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic                aw_done, aw_done_d, w_done, w_done_d;
  logic                reload_d, resp_err_d;

  // Single-beat, full-word transfers only; IDs are constant.
  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  // Response IDs and rlast carry no information for single outstanding beats.
  logic unused_ok;
  assign unused_ok = ^{rid, rlast, bid};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata    <= '0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      reload   <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata    <= rdata_d;
      arvalid  <= arvalid_d;
      rready   <= rready_d;
      awvalid  <= awvalid_d;
      wvalid   <= wvalid_d;
      bready   <= bready_d;
      aw_done  <= aw_done_d;
      w_done   <= w_done_d;
      reload   <= reload_d;
      resp_err <= resp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata;
    arvalid_d  = arvalid;
    rready_d   = rready;
    awvalid_d  = awvalid;
    wvalid_d   = wvalid;
    bready_d   = bready;
    aw_done_d  = aw_done;
    w_done_d   = w_done;
    reload_d   = 1'b0;
    resp_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_en) begin
          addr_d = req_addr;
          if (req_wsel == '0) begin
            arvalid_d = 1'b1;
            state_d   = ST_AR;
          end else begin
            wdata_d   = req_wdata;
            wstrb_d   = req_wsel;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_AW_W;
          end
        end
      end
      ST_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (rvalid && rready) begin
          rdata_d    = rdata_axi;
          resp_err_d = (rresp != AXI_RESP_OKAY);
          rready_d   = 1'b0;
          reload_d   = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_AW_W: begin
        // Address and data channels complete independently, in any order.
        if (awvalid && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_B;
        end
      end
      ST_B: begin
        if (bvalid && bready) begin
          resp_err_d = (bresp != AXI_RESP_OKAY);
          bready_d   = 1'b0;
          reload_d   = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        // req_en is still high here; ignoring it prevents a duplicate issue.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Directed bench for uncache_axi_bridge: the bench plays both the upstream
// requester and a hand-stepped AXI slave.
module tb_uncache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en;
  logic [3:0]  req_wsel;
  logic [31:0] req_addr, req_wdata;
  logic        reload, resp_err;
  logic [31:0] rdata;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata_axi, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;
  int reload_cnt = 0, ar_hs = 0, aw_hs = 0, w_hs = 0;
  int base_rl, base_ar, base_aw, base_w;

  uncache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .req_en(req_en), .req_wsel(req_wsel), .req_addr(req_addr), .req_wdata(req_wdata),
    .reload(reload), .rdata(rdata), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Handshake and completion counters observed at the active edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (reload)            reload_cnt++;
      if (arvalid && arready) ar_hs++;
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready)   w_hs++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait read starting from IDLE; leaves the bench one cycle after reload.
  task automatic read_zw(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] resp, input logic exp_err);
    req_en = 1'b1; req_wsel = 4'b0; req_addr = a;
    step();
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd1);
    chk({tag, "_araddr"}, araddr, a);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk({tag, "_rready"}, 32'(rready), 32'd1);
    rvalid = 1'b1; rdata_axi = d; rresp = resp;
    step();
    rvalid = 1'b0; req_en = 1'b0;
    chk({tag, "_reload"}, 32'(reload), 32'd1);
    chk({tag, "_rdata"}, rdata, d);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    step();
    chk({tag, "_reload_end"}, 32'(reload), 32'd0);
    chk({tag, "_err_end"}, 32'(resp_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_en = 1'b0; req_wsel = '0; req_addr = '0; req_wdata = '0;
    arready = 1'b0; rid = 4'h1; rdata_axi = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'h1; bresp = '0; bvalid = 1'b0;
    step(); step();
    chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    chk("rst_reload", 32'({reload, resp_err}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", araddr, 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait read with fixed-field checks on the request cycle.
    base_rl = reload_cnt;
    req_en = 1'b1; req_wsel = 4'b0; req_addr = 32'h1faf_f000;
    step();
    chk("rd_arvalid", 32'(arvalid), 32'd1);
    chk("rd_araddr", araddr, 32'h1faf_f000);
    chk("rd_fixed", {arid, arlen, arsize, arburst, 15'd0}, {4'h1, 8'd0, 3'b010, 2'b01, 15'd0});
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rd_arvalid_drop", 32'(arvalid), 32'd0);
    chk("rd_rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata_axi = 32'hdead_beef; rresp = 2'b00;
    step();
    rvalid = 1'b0; req_en = 1'b0;
    chk("rd_reload", 32'(reload), 32'd1);
    chk("rd_rdata", rdata, 32'hdead_beef);
    chk("rd_err", 32'(resp_err), 32'd0);
    chk("rd_rready_drop", 32'(rready), 32'd0);
    step(); step();
    chk("rd_one_reload", 32'(reload_cnt - base_rl), 32'd1);

    // Write: W accepted on cycle 1, AW held off until cycle 4.
    base_rl = reload_cnt; base_aw = aw_hs; base_w = w_hs;
    req_en = 1'b1; req_wsel = 4'b0011; req_addr = 32'h0000_1004; req_wdata = 32'h1234_5678;
    step();
    chk("wr_valids", 32'({awvalid, wvalid}), 32'b11);
    chk("wr_wstrb", 32'(wstrb), 32'h3);
    chk("wr_wdata", wdata, 32'h1234_5678);
    chk("wr_awaddr", awaddr, 32'h0000_1004);
    chk("wr_fixed", {awid, awlen, awsize, awburst, wlast, 14'd0},
        {4'h1, 8'd0, 3'b010, 2'b01, 1'b1, 14'd0});
    wready = 1'b1;
    req_addr = 32'hffff_ffff; req_wdata = 32'h0;
    step();
    wready = 1'b0;
    chk("wr_w_done", 32'({awvalid, wvalid, bready}), 32'b100);
    chk("wr_awaddr_stable", awaddr, 32'h0000_1004);
    step();
    chk("wr_wait_c3", 32'({awvalid, wvalid, bready}), 32'b100);
    step();
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("wr_bready", 32'({awvalid, wvalid, bready}), 32'b001);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0; req_en = 1'b0;
    chk("wr_reload", 32'({reload, resp_err, bready}), 32'b100);
    chk("wr_rdata_kept", rdata, 32'hdead_beef);
    step(); step();
    chk("wr_counts", {8'(reload_cnt - base_rl), 8'(aw_hs - base_aw), 8'(w_hs - base_w), 8'd0},
        {8'd1, 8'd1, 8'd1, 8'd0});

    // Read with AR backpressure for 5 cycles, then SLVERR response.
    base_ar = ar_hs;
    req_en = 1'b1; req_wsel = 4'b0; req_addr = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_arvalid", 32'(arvalid), 32'd1);
      chk("bp_araddr", araddr, 32'h0000_2000);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("bp_ar_once", 32'({28'(ar_hs - base_ar), arvalid, 3'd0}), {28'd1, 1'b0, 3'd0});
    rvalid = 1'b1; rdata_axi = 32'hcafe_f00d; rresp = 2'b10;
    step();
    rvalid = 1'b0; req_en = 1'b0;
    chk("err_reload_err", 32'({reload, resp_err}), 32'b11);
    chk("err_rdata", rdata, 32'hcafe_f00d);
    step();
    chk("err_clear", 32'({reload, resp_err}), 32'b00);
    step();
    read_zw("ok_after_err", 32'h0000_3000, 32'h0bad_f00d, 2'b00, 1'b0);

    // Back-to-back: write, then read requested on the reload cycle.
    base_rl = reload_cnt; base_ar = ar_hs; base_aw = aw_hs;
    req_en = 1'b1; req_wsel = 4'b1111; req_addr = 32'h0000_4000; req_wdata = 32'haaaa_5555;
    step();
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("b2b_bready", 32'(bready), 32'd1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("b2b_wr_reload", 32'(reload), 32'd1);
    req_wsel = 4'b0; req_addr = 32'h0000_5000;
    step();
    chk("b2b_done_idle", 32'({arvalid, awvalid, wvalid, reload}), 32'd0);
    step();
    chk("b2b_arvalid", 32'({arvalid, awvalid}), 32'b10);
    chk("b2b_araddr", araddr, 32'h0000_5000);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata_axi = 32'h5a5a_a5a5; rresp = 2'b00;
    step();
    rvalid = 1'b0; req_en = 1'b0;
    chk("b2b_rd_reload", 32'(reload), 32'd1);
    chk("b2b_rdata", rdata, 32'h5a5a_a5a5);
    step(); step();
    chk("b2b_counts", {8'(reload_cnt - base_rl), 8'(ar_hs - base_ar), 8'(aw_hs - base_aw), 8'd0},
        {8'd2, 8'd1, 8'd1, 8'd0});

    // Reset while waiting in R with rvalid low.
    base_rl = reload_cnt;
    req_en = 1'b1; req_wsel = 4'b0; req_addr = 32'h0000_6000;
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rst_mid_rready", 32'(rready), 32'd1);
    rst = 1'b1; req_en = 1'b0;
    step();
    chk("rst_mid_valids", 32'({arvalid, rready, awvalid, wvalid, bready, reload}), 32'd0);
    rst = 1'b0;
    rvalid = 1'b1; rdata_axi = 32'h1111_1111;
    step(); step(); step();
    rvalid = 1'b0;
    chk("rst_mid_no_reload", 32'(reload_cnt - base_rl), 32'd0);
    chk("rst_mid_idle", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
